// File: rtl/simmem_pkg.sv
// Purpose: shared defaults and pointer/address types for the simmem response bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simmem_pkg;

   localparam int DefNumIds     = 4;
   localparam int DefDepthPerId = 8;
   localparam int DefDataWidth  = 16;

   // Per-ID queue pointer: slot index plus one wrap bit above it.
   typedef logic [$clog2(DefDepthPerId):0]             resp_bank_ptr_t;
   // Flat storage address {id, slot}.
   typedef logic [$clog2(DefNumIds*DefDepthPerId)-1:0] resp_bank_addr_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Purpose: round-robin arbiter picking one requester, priority starts after the last advanced grant.
// Latency: combinational grant; priority pointer and lock update on the clock edge.
// Backpressure: a grant not advanced is locked and re-presented until advance_i.
//
// Ports: clk_i/rst_ni (sync active-low), req_i request vector, gnt_o one-hot grant,
//        advance_i consumes the current grant.
module simmem_rr_arbiter #(
   parameter int NumReq = 4,
   localparam int IdxW  = $clog2(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] gnt_o,
   input  logic              advance_i
);

   logic [IdxW-1:0] prio_q, prio_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic            locked_q, locked_d;
   logic [IdxW-1:0] sel_idx;
   logic [IdxW-1:0] cand;
   logic            sel_found;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      // NumReq is a power of two, so the index sum wraps naturally.
      for (int i = 0; i < NumReq; i++) begin
         cand = prio_q + IdxW'(i);
         if (!sel_found && req_i[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      // A stalled grant must not move even if a higher-priority requester appears.
      if (locked_q) begin
         sel_found = 1'b1;
         sel_idx   = lock_idx_q;
      end

      gnt_o = '0;
      if (sel_found) gnt_o[sel_idx] = 1'b1;

      prio_d     = prio_q;
      locked_d   = 1'b0;
      lock_idx_d = lock_idx_q;
      if (sel_found && advance_i) begin
         prio_d = sel_idx + IdxW'(1);
      end else if (sel_found) begin
         locked_d   = 1'b1;
         lock_idx_d = sel_idx;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q     <= '0;
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         prio_q     <= prio_d;
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: rtl/simmem_multi_id_resp_bank.sv
// Purpose: per-ID circular response queues: reserve slot, fill in order, release, emit round-robin.
// Latency: same-cycle output from eligibility; +1 cycle with SIMMEM_RESP_BANK_OUT_REG_EN (registered, skid).
// Backpressure: out_ready_i low holds out_id_o/out_data_o; full ID queue drops only that ID's res_req_ready_o.
//
// Ports: clk_i/rst_ni (sync active-low); res_req_* reserve a slot, res_addr_o = {id, slot} reserved;
//        in_* fill the oldest reserved slot of in_id_i; release_en_i per-ID release pulse,
//        released_addr_mhot_o flags released slots; out_* emit handshake.
// Configuration macro: SIMMEM_RESP_BANK_OUT_REG_EN selects the registered output stage.
module simmem_multi_id_resp_bank
   import simmem_pkg::*;
#(
   parameter int NumIds     = DefNumIds,
   parameter int DepthPerId = DefDepthPerId,
   parameter int DataWidth  = DefDataWidth,
   localparam int IdWidth   = $clog2(NumIds),
   localparam int PtrWidth  = $clog2(DepthPerId) + 1,
   localparam int AddrWidth = $clog2(NumIds*DepthPerId)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [IdWidth-1:0]           res_req_id_i,
   input  logic                         res_req_valid_i,
   output logic                         res_req_ready_o,
   output logic [AddrWidth-1:0]         res_addr_o,
   input  logic [IdWidth-1:0]           in_id_i,
   input  logic [DataWidth-1:0]         in_data_i,
   input  logic                         in_data_valid_i,
   output logic                         in_data_ready_o,
   input  logic [NumIds-1:0]            release_en_i,
   output logic [NumIds*DepthPerId-1:0] released_addr_mhot_o,
   output logic [IdWidth-1:0]           out_id_o,
   output logic [DataWidth-1:0]         out_data_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i
);

   localparam int SlotWidth = PtrWidth - 1;
   localparam int NumSlots  = NumIds * DepthPerId;
   localparam logic [PtrWidth-1:0] PtrFull = PtrWidth'(DepthPerId);
   localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

   logic [PtrWidth-1:0]  res_q [NumIds];
   logic [PtrWidth-1:0]  res_d [NumIds];
   logic [PtrWidth-1:0]  fill_q[NumIds];
   logic [PtrWidth-1:0]  fill_d[NumIds];
   logic [PtrWidth-1:0]  rel_q [NumIds];
   logic [PtrWidth-1:0]  rel_d [NumIds];
   logic [PtrWidth-1:0]  out_q [NumIds];
   logic [PtrWidth-1:0]  out_d [NumIds];
   logic [DataWidth-1:0] mem_q [NumSlots];

   logic                 res_fire;
   logic                 fill_fire;
   logic                 pop_vld;   // head of gnt_id leaves the bank this cycle
   logic [NumIds-1:0]    rel_fire;
   logic [NumIds-1:0]    elig;
   logic [NumIds-1:0]    gnt;
   logic [IdWidth-1:0]   gnt_id;
   logic [DataWidth-1:0] head_dat;

   // Occupancy counts every slot not yet emitted, so released/filled heads still block reuse.
   assign res_req_ready_o = (res_q[res_req_id_i] - out_q[res_req_id_i]) != PtrFull;
   assign res_addr_o      = {res_req_id_i, res_q[res_req_id_i][SlotWidth-1:0]};
   // Registered res_q: a same-cycle reservation cannot be filled until the next cycle.
   assign in_data_ready_o = fill_q[in_id_i] != res_q[in_id_i];
   assign res_fire        = res_req_valid_i && res_req_ready_o;
   assign fill_fire       = in_data_valid_i && in_data_ready_o;

   always_comb begin
      released_addr_mhot_o = '0;
      rel_fire             = '0;
      elig                 = '0;
      for (int i = 0; i < NumIds; i++) begin
         rel_fire[i] = release_en_i[i] && (rel_q[i] != res_q[i]);
         if (rel_fire[i]) begin
            released_addr_mhot_o[{IdWidth'(i), rel_q[i][SlotWidth-1:0]}] = 1'b1;
         end
         // Head must be both released and filled before it can be emitted.
         elig[i] = (out_q[i] != rel_q[i]) && (out_q[i] != fill_q[i]);
      end
   end

   simmem_rr_arbiter #(
      .NumReq (NumIds)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (elig),
      .gnt_o     (gnt),
      .advance_i (pop_vld)
   );

   always_comb begin
      gnt_id = '0;
      for (int i = 0; i < NumIds; i++) begin
         if (gnt[i]) gnt_id = IdWidth'(i);
      end
   end

   assign head_dat = mem_q[{gnt_id, out_q[gnt_id][SlotWidth-1:0]}];

   always_comb begin
      for (int i = 0; i < NumIds; i++) begin
         res_d[i]  = res_q[i];
         fill_d[i] = fill_q[i];
         rel_d[i]  = rel_q[i];
         out_d[i]  = out_q[i];
         if (res_fire && (res_req_id_i == IdWidth'(i))) res_d[i]  = res_q[i] + PtrOne;
         if (fill_fire && (in_id_i == IdWidth'(i)))     fill_d[i] = fill_q[i] + PtrOne;
         if (rel_fire[i])                               rel_d[i]  = rel_q[i] + PtrOne;
         if (pop_vld && (gnt_id == IdWidth'(i)))        out_d[i]  = out_q[i] + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumIds; i++) begin
            res_q[i]  <= '0;
            fill_q[i] <= '0;
            rel_q[i]  <= '0;
            out_q[i]  <= '0;
         end
      end else begin
         res_q  <= res_d;
         fill_q <= fill_d;
         rel_q  <= rel_d;
         out_q  <= out_d;
      end
   end

   // Response storage is not reset; only filled slots are ever read.
   always_ff @(posedge clk_i) begin
      if (fill_fire) mem_q[{in_id_i, fill_q[in_id_i][SlotWidth-1:0]}] <= in_data_i;
   end

`ifdef SIMMEM_RESP_BANK_OUT_REG_EN
   logic                 ov_q, ov_d, sv_q, sv_d;
   logic [IdWidth-1:0]   oid_q, oid_d, sid_q, sid_d;
   logic [DataWidth-1:0] odat_q, odat_d, sdat_q, sdat_d;

   // Upstream ready depends only on the skid flop, keeping out_ready_i off the bank's paths.
   assign pop_vld = (|elig) && !sv_q;

   always_comb begin
      ov_d   = ov_q;
      oid_d  = oid_q;
      odat_d = odat_q;
      sv_d   = sv_q;
      sid_d  = sid_q;
      sdat_d = sdat_q;
      if (!ov_q || out_ready_i) begin
         if (sv_q) begin
            ov_d   = 1'b1;
            oid_d  = sid_q;
            odat_d = sdat_q;
            sv_d   = 1'b0;
         end else begin
            ov_d   = pop_vld;
            oid_d  = pop_vld ? gnt_id : '0;
            odat_d = pop_vld ? head_dat : '0;
         end
      end else if (pop_vld) begin
         sv_d   = 1'b1;
         sid_d  = gnt_id;
         sdat_d = head_dat;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ov_q   <= 1'b0;
         oid_q  <= '0;
         odat_q <= '0;
         sv_q   <= 1'b0;
         sid_q  <= '0;
         sdat_q <= '0;
      end else begin
         ov_q   <= ov_d;
         oid_q  <= oid_d;
         odat_q <= odat_d;
         sv_q   <= sv_d;
         sid_q  <= sid_d;
         sdat_q <= sdat_d;
      end
   end

   assign out_valid_o = ov_q;
   assign out_id_o    = oid_q;
   assign out_data_o  = odat_q;
`else
   assign out_valid_o = |elig;
   assign out_id_o    = gnt_id;
   assign out_data_o  = out_valid_o ? head_dat : '0;
   assign pop_vld     = out_valid_o && out_ready_i;
`endif

endmodule
